// File: rtl/uart_imem_loader.sv
// Boot loader: assembles UART bytes little-endian into words, writes them to
// consecutive instruction-memory addresses and holds the core until a terminator run.
module uart_imem_loader #(
    parameter int                WORD_W         = 32,
    parameter int                DEPTH          = 64,
    parameter int                ADDR_W         = 6,
    parameter logic [WORD_W-1:0] TERM_WORD      = {WORD_W{1'b1}},
    parameter int                TERM_COUNT     = 2,
    parameter int                TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              write_done,
    output logic              err_timeout,
    output logic              err_overflow,
    output logic              cpu_hold
);

    localparam int LANES = WORD_W / 8;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RUN_W = $clog2(TERM_COUNT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_full;
    logic [RUN_W-1:0]  term_run;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] wr_addr;

    logic accept, last_byte, full, word_done, write_ok, overflow, term_hit, timeout_hit;

    assign accept    = rx_valid && load_en && !rx_break && (state == S_LOAD);
    assign last_byte = (idx == IDX_W'(LANES - 1));
    // A write still in flight counts against capacity before words_loaded catches up.
    assign full      = (CNT_W'(words_loaded) + CNT_W'(mem_we)) >= CNT_W'(DEPTH);
    assign word_done = accept && last_byte;
    assign overflow  = word_done && full;
    assign write_ok  = word_done && !full;
    assign term_hit  = mem_we && (mem_wdata == TERM_WORD) &&
                       (term_run == RUN_W'(TERM_COUNT - 1));
    assign timeout_hit = (state == S_LOAD) && load_en && (idx != '0) && !accept &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign write_done = (state == S_DONE);
    assign cpu_hold   = (state != S_DONE);

    always_comb begin
        word_full = word_buf;
        word_full[int'(idx)*8 +: 8] = rx_data;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (rx_break) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (overflow)      state_nxt = S_ERROR;
                    else if (term_hit) state_nxt = S_DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            word_buf     <= '0;
            term_run     <= '0;
            to_cnt       <= '0;
            wr_addr      <= '0;
            words_loaded <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (rx_break) begin
            idx          <= '0;
            word_buf     <= '0;
            term_run     <= '0;
            to_cnt       <= '0;
            wr_addr      <= '0;
            words_loaded <= '0;
            mem_we       <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= write_ok;
            if (write_ok) begin
                mem_wdata <= word_full;
                mem_addr  <= mem_we ? wr_addr + 1'b1 : wr_addr;
            end

            if (mem_we) begin
                wr_addr      <= wr_addr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
                term_run     <= (mem_wdata == TERM_WORD) ? term_run + 1'b1 : '0;
            end

            // Partial-word watchdog: only ticks while a word is half assembled.
            if (accept) begin
                word_buf[int'(idx)*8 +: 8] <= rx_data;
                idx    <= last_byte ? '0 : idx + 1'b1;
                to_cnt <= '0;
            end else if (timeout_hit) begin
                idx         <= '0;
                to_cnt      <= '0;
                err_timeout <= 1'b1;
            end else if ((state == S_LOAD) && load_en && (idx != '0)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (overflow) err_overflow <= 1'b1;
        end
    end

endmodule
